// File: rtl/div_if.sv
// Controller-side bundle for the iterative divider: operand/request signals
// from the controller and busy/done/result signals back from the divider.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV / DIVU), one quotient bit per clock.
// IDLE -> LOAD -> RUN (WIDTH cycles) -> FIX -> IDLE; divide-by-zero skips RUN.
// Optional build macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the
// operation also skips RUN and returns quotient 0, remainder = dividend.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, b_r;          // raw operands captured at acceptance
  logic             sgn_r;
  logic [WIDTH-1:0] dvd_r;             // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0] dvs_r;             // divisor magnitude
  logic [WIDTH-1:0] p_r;               // partial remainder; always < divisor so WIDTH bits hold it
  logic [CW-1:0]    cnt_r;
  logic             dz_r, eo_r;
  logic             busy_r, done_r, dbz_r;
  logic [WIDTH-1:0] quot_r, rem_r;

  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [WIDTH:0]   shift_s, diff_s;   // WIDTH+1-bit shifted P and trial difference
  logic             qbit_s, early_s, b_zero_s, neg_q_s, neg_r_s;
  logic [WIDTH-1:0] fix_q_s, fix_r_s;

  // Magnitude of a value; the most-negative pattern maps onto itself as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    if (s && v[WIDTH-1]) begin
      mag = ~v + ONE_W;
    end else begin
      mag = v;
    end
  endfunction

  assign mag_a_s  = mag(a_r, sgn_r);
  assign mag_b_s  = mag(b_r, sgn_r);
  assign b_zero_s = (b_r == ZERO_W);
  assign shift_s  = {p_r, dvd_r[WIDTH-1]};
  assign diff_s   = shift_s - {1'b0, dvs_r};
  assign qbit_s   = ~diff_s[WIDTH];
  assign neg_q_s  = sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
  assign neg_r_s  = sgn_r & a_r[WIDTH-1];

`ifdef DIV_EARLY_OUT_EN
  assign early_s = (mag_a_s < mag_b_s);
`else
  assign early_s = 1'b0;
`endif

  // Next-state logic for the control FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) state_s = S_LOAD;
        else           state_s = S_IDLE;
      end
      S_LOAD: begin
        if (b_zero_s || early_s) state_s = S_FIX;
        else                     state_s = S_RUN;
      end
      S_RUN: begin
        if (cnt_r == CNT_ONE) state_s = S_FIX;
        else                  state_s = S_RUN;
      end
      S_FIX:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Final result selection with sign correction (two's complement, mod 2^WIDTH).
  always_comb begin
    fix_q_s = dvd_r;
    fix_r_s = p_r;
    if (dz_r) begin
      fix_q_s = ONES_W;
      fix_r_s = a_r;
    end else if (eo_r) begin
      fix_q_s = ZERO_W;
      fix_r_s = a_r;
    end else begin
      fix_q_s = neg_q_s ? (~dvd_r + ONE_W) : dvd_r;
      fix_r_s = neg_r_s ? (~p_r + ONE_W) : p_r;
    end
  end

  // State register plus registered busy/done handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != S_IDLE);
      done_r  <= (state_r == S_FIX);
    end
  end

  // Operand capture and the shift/subtract datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= ZERO_W;
      b_r   <= ZERO_W;
      sgn_r <= 1'b0;
      dvd_r <= ZERO_W;
      dvs_r <= ZERO_W;
      p_r   <= ZERO_W;
      cnt_r <= {CW{1'b0}};
      dz_r  <= 1'b0;
      eo_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            a_r   <= bus.dividend;
            b_r   <= bus.divisor;
            sgn_r <= bus.is_signed;
          end
        end
        S_LOAD: begin
          dvd_r <= mag_a_s;
          dvs_r <= mag_b_s;
          p_r   <= ZERO_W;
          cnt_r <= CNT_LOAD;
          dz_r  <= b_zero_s;
          eo_r  <= ~b_zero_s & early_s;
        end
        S_RUN: begin
          // restoring step: keep the difference when non-negative, else the shifted P
          p_r   <= qbit_s ? diff_s[WIDTH-1:0] : shift_s[WIDTH-1:0];
          dvd_r <= {dvd_r[WIDTH-2:0], qbit_s};
          cnt_r <= cnt_r - CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers; updated only on the FIX cycle so they hold across a new busy period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot_r <= ZERO_W;
      rem_r  <= ZERO_W;
      dbz_r  <= 1'b0;
    end else if (state_r == S_FIX) begin
      quot_r <= fix_q_s;
      rem_r  <= fix_r_s;
      dbz_r  <= dz_r;
    end else begin
      quot_r <= quot_r;
      rem_r  <= rem_r;
      dbz_r  <= dbz_r;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_div_unit.sv
// Table-driven bench for div_unit plus handshake/reset sequences.
// Latency expectations follow the DIV_EARLY_OUT_EN build setting.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;

  div_if #(.WIDTH(32)) bus();
  div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = 34;
`endif

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  int nvec = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
      errs++;
    end
  endtask

  // drive a request for one edge, then scramble the operand inputs
  task automatic do_start(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.dividend  = 32'hDEADBEEF;
    bus.divisor   = 32'h00000000;
    bus.is_signed = ~s;
  endtask

  // count edges until done is seen (bounded)
  task automatic wait_done(output int lat);
    bit found;
    found = 1'b0;
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
      errs++;
    end
  endtask

  initial begin
    int lat;
    logic [31:0] prev_q;

    vt[0]  = '{1'b0, 32'd100,       32'd7,        32'h0000000E, 32'h00000002, 1'b0, 34};
    vt[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
    vt[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 34};
    vt[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 34};
    vt[4]  = '{1'b0, 32'h12345678,  32'h00000000, 32'hFFFFFFFF, 32'h12345678, 1'b1, 2};
    vt[5]  = '{1'b1, 32'hFFFFFF9C,  32'h00000000, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1, 2};
    vt[6]  = '{1'b0, 32'd5,         32'd9,        32'h00000000, 32'h00000005, 1'b0, EO_LAT};
    vt[7]  = '{1'b1, 32'hFFFFFFFD,  32'd5,        32'h00000000, 32'hFFFFFFFD, 1'b0, EO_LAT};
    vt[8]  = '{1'b0, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 32'h00000000, 1'b0, 34};
    vt[9]  = '{1'b0, 32'hFFFFFFFF,  32'd10,       32'h19999999, 32'h00000005, 1'b0, 34};
    vt[10] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 1'b0, 34};
    vt[11] = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, EO_LAT};
    vt[12] = '{1'b1, 32'h80000000,  32'd2,        32'hC0000000, 32'h00000000, 1'b0, 34};

    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = 32'h0;
    bus.divisor = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nvec++;
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    chk("reset_quotient", bus.quotient, 32'h0);
    chk("reset_remainder", bus.remainder, 32'h0);
    chk("reset_dbz", 32'(bus.div_by_zero), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    prev_q = 32'h0;
    for (int i = 0; i < NV; i++) begin
      nvec++;
      do_start(vt[i].sgn, vt[i].a, vt[i].b);
      chk($sformatf("v%0d_busy_after_start", i), 32'(bus.busy), 32'h1);
      chk($sformatf("v%0d_hold_quotient", i), bus.quotient, prev_q);
      wait_done(lat);
      chk($sformatf("v%0d_quotient", i), bus.quotient, vt[i].q);
      chk($sformatf("v%0d_remainder", i), bus.remainder, vt[i].r);
      chk($sformatf("v%0d_dbz", i), 32'(bus.div_by_zero), 32'(vt[i].dz));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_busy_in_done", i), 32'(bus.busy), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_one_cycle", i), 32'(bus.done), 32'h0);
      prev_q = vt[i].q;
    end

    // start while busy is ignored
    nvec++;
    do_start(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    chk("hs1_busy", 32'(bus.busy), 32'h1);
    bus.dividend = 32'd9;
    bus.divisor = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat);
    chk("hs1_latency", 32'(lat + 11), 32'd34);
    chk("hs1_quotient", bus.quotient, 32'h0000000E);
    chk("hs1_remainder", bus.remainder, 32'h00000002);

    // start in the done cycle is accepted
    nvec++;
    do_start(1'b0, 32'd9, 32'd3);
    chk("hs2_accept_busy", 32'(bus.busy), 32'h1);
    chk("hs2_accept_done_low", 32'(bus.done), 32'h0);
    chk("hs2_hold_quotient", bus.quotient, 32'h0000000E);
    wait_done(lat);
    chk("hs2_latency", 32'(lat), 32'd34);
    chk("hs2_quotient", bus.quotient, 32'h00000003);
    chk("hs2_remainder", bus.remainder, 32'h00000000);

    // async reset mid-RUN, then a clean operation
    nvec++;
    do_start(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("hs3_rst_busy", 32'(bus.busy), 32'h0);
    chk("hs3_rst_done", 32'(bus.done), 32'h0);
    chk("hs3_rst_quotient", bus.quotient, 32'h0);
    chk("hs3_rst_remainder", bus.remainder, 32'h0);
    chk("hs3_rst_dbz", 32'(bus.div_by_zero), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start(1'b0, 32'd200, 32'd9);
    wait_done(lat);
    chk("hs3_latency", 32'(lat), 32'd34);
    chk("hs3_quotient", bus.quotient, 32'h00000016);
    chk("hs3_remainder", bus.remainder, 32'h00000002);
    chk("hs3_dbz", 32'(bus.div_by_zero), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
